// File: rtl/bpsk_pkg.sv
// Shared defaults and helpers for the BPSK hard-decision demapper.
// Polarity constant fixes which sign of the soft sample decides a 1.
package bpsk_pkg;

  localparam int unsigned SW_DEF     = 8;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned THRESH_DEF = 4;
  localparam int unsigned CW_DEF     = 16;

  // Bit value decided for a non-negative sample (transmit map 1 -> +1).
  localparam logic BPSK_BIT_POS = 1'b1;

  // Magnitude of a sign-extended sample; one extra bit so the most negative
  // value maps to +2^31 instead of wrapping.
  function automatic logic [32:0] sat_mag(input logic signed [31:0] x);
    logic signed [32:0] xe;
    xe = {x[31], x};
    return x[31] ? -xe : xe;
  endfunction

endpackage

// File: rtl/bpsk_demapper_if.sv
// Symbol-in / word-out handshake bundle for bpsk_demapper.
// slave: the demapper side; master: the source/sink side.
interface bpsk_demapper_if
  import bpsk_pkg::*;
#(
  parameter int unsigned SW = SW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
);

  logic signed [SW-1:0] sym_i;
  logic                 sym_valid_i;
  logic                 sym_ready_o;
  logic                 sync_clr_i;
  logic [DW-1:0]        dout_o;
  logic                 dout_valid_o;
  logic                 dout_ready_i;
  logic [CW-1:0]        lowconf_cnt_o;

  modport slave (
    input  sym_i, sym_valid_i, sync_clr_i, dout_ready_i,
    output sym_ready_o, dout_o, dout_valid_o, lowconf_cnt_o
  );

  modport master (
    output sym_i, sym_valid_i, sync_clr_i, dout_ready_i,
    input  sym_ready_o, dout_o, dout_valid_o, lowconf_cnt_o
  );

endinterface

// File: rtl/bpsk_bit_packer.sv
// Packs decided bits MSB-first into DW-bit words with a valid/ready output.
// Only the word-completing bit can stall, and only while the output is held.
module bpsk_bit_packer #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_accept,
  input  logic          i_bit,
  input  logic          i_clr,
  input  logic          i_dout_ready,
  output logic          o_ready,
  output logic [DW-1:0] o_dout,
  output logic          o_dout_valid
);

  localparam int unsigned     CntW    = $clog2(DW);
  localparam logic [CntW-1:0] LastCnt = CntW'(DW - 1);

  logic [CntW-1:0] r_cnt;
  logic [DW-2:0]   r_shift;
  logic [DW-1:0]   r_dout;
  logic            r_valid;

  logic            w_last;
  logic            w_load;
  logic [DW-1:0]   w_word;

  assign w_last  = (r_cnt == LastCnt);
  assign w_word  = {r_shift, i_bit};
  assign w_load  = i_accept & w_last;
  assign o_ready = ~(w_last & r_valid & ~i_dout_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_clr) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (i_accept) begin
        r_shift <= w_word[DW-2:0];
        r_cnt   <= w_last ? '0 : r_cnt + CntW'(1);
      end
      // A new word loading outranks the drain of the old one.
      if (w_load) begin
        r_dout  <= w_word;
        r_valid <= 1'b1;
      end else if (r_valid && i_dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;

endmodule

// File: rtl/bpsk_demapper.sv
// BPSK sign slicer with optional DBPSK decoding (BPSK_DIFF_DECODE_EN),
// bit packer and saturating low-confidence decision counter.
module bpsk_demapper
  import bpsk_pkg::*;
#(
  parameter int unsigned SW     = SW_DEF,
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned THRESH = THRESH_DEF,
  parameter int unsigned CW     = CW_DEF
) (
  input logic             clk,
  input logic             rst,
  bpsk_demapper_if.slave  bus
);

  logic               w_pk_ready;
  logic               w_accept;
  logic               w_dec;
  logic               w_bit;
  logic               w_low;
  logic signed [31:0] w_sym_ext;
  logic [32:0]        w_mag;
  logic [CW-1:0]      r_lowconf;

  assign bus.sym_ready_o = w_pk_ready & ~bus.sync_clr_i;
  assign w_accept        = bus.sym_valid_i & bus.sym_ready_o;

  // Exact zero counts as non-negative.
  assign w_dec = bus.sym_i[SW-1] ? ~BPSK_BIT_POS : BPSK_BIT_POS;

`ifdef BPSK_DIFF_DECODE_EN
  logic r_ref;

  assign w_bit = w_dec ^ r_ref;

  always_ff @(posedge clk) begin
    if (rst || bus.sync_clr_i) begin
      r_ref <= 1'b0;
    end else if (w_accept) begin
      r_ref <= w_dec;
    end
  end
`else
  assign w_bit = w_dec;
`endif

  assign w_sym_ext = 32'($signed(bus.sym_i));
  assign w_mag     = sat_mag(w_sym_ext);
  assign w_low     = (w_mag < 33'(THRESH));

  always_ff @(posedge clk) begin
    if (rst || bus.sync_clr_i) begin
      r_lowconf <= '0;
    end else if (w_accept && w_low && (r_lowconf != {CW{1'b1}})) begin
      r_lowconf <= r_lowconf + CW'(1);
    end
  end

  assign bus.lowconf_cnt_o = r_lowconf;

  bpsk_bit_packer #(
    .DW (DW)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_accept     (w_accept),
    .i_bit        (w_bit),
    .i_clr        (bus.sync_clr_i),
    .i_dout_ready (bus.dout_ready_i),
    .o_ready      (w_pk_ready),
    .o_dout       (bus.dout_o),
    .o_dout_valid (bus.dout_valid_o)
  );

endmodule

// File: tb/tb_bpsk_demapper.sv
// Directed plus randomized bench for bpsk_demapper against a queue-based model.
// Honours BPSK_DIFF_DECODE_EN in both the model and the directed constants.
module tb_bpsk_demapper;
  import bpsk_pkg::*;

  localparam int SW     = 8;
  localparam int DW     = 8;
  localparam int THRESH = 4;
  localparam int CW     = 16;
  localparam int CW_S   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpsk_demapper_if #(.SW(SW), .DW(DW), .CW(CW))   b ();
  bpsk_demapper_if #(.SW(SW), .DW(DW), .CW(CW_S)) bs ();

  bpsk_demapper #(.SW(SW), .DW(DW), .THRESH(THRESH), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  bpsk_demapper #(.SW(SW), .DW(DW), .THRESH(THRESH), .CW(CW_S)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bs)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: decided bits collected in arrival order.
  bit            m_bits[$];
  bit            m_ref;
  int            m_low;
  logic [DW-1:0] m_last_word;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_bits.delete();
    m_ref = 1'b0;
    m_low = 0;
  endtask

  task automatic model_accept(input int v, output bit done);
    bit d;
    bit pb;
    int mag;
    d = (v >= 0);
`ifdef BPSK_DIFF_DECODE_EN
    pb    = d ^ m_ref;
    m_ref = d;
`else
    pb = d;
`endif
    m_bits.push_back(pb);
    mag = (v < 0) ? -v : v;
    if (mag < THRESH && m_low < (2 ** CW) - 1) m_low++;
    done = 1'b0;
    if (m_bits.size() == DW) begin
      m_last_word = '0;
      for (int i = 0; i < DW; i++) if (m_bits[i]) m_last_word += DW'(1) << (DW - 1 - i);
      m_bits.delete();
      done = 1'b1;
    end
  endtask

  // Entered and left at a negedge; inputs change only there.
  task automatic send(input int v, input string tag);
    int g;
    bit done;
    g = 0;
    b.sym_i       = SW'(v);
    b.sym_valid_i = 1'b1;
    #1;
    while (b.sym_ready_o !== 1'b1 && g < 50) begin
      if (g == 3) b.dout_ready_i = 1'b1;
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 50) begin
      check({tag, "_ready_timeout"}, 32'(b.sym_ready_o), 32'd1);
      @(negedge clk);
      b.sym_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(v, done);
    @(negedge clk);
    b.sym_valid_i = 1'b0;
    check({tag, "_lowconf"}, 32'(b.lowconf_cnt_o), 32'(m_low));
    if (done) begin
      check({tag, "_valid"}, 32'(b.dout_valid_o), 32'd1);
      check({tag, "_dout"}, 32'(b.dout_o), 32'(m_last_word));
    end
  endtask

  function automatic int rand_sample();
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 10)) - 5;
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int            tv1[8] = '{5, -3, 1, 0, -128, 127, -1, 2};
    int            tv2[8] = '{20, 7, -9, -50, 3, -1, -100, -2};
    int            s8;
    logic [DW-1:0] word_a;

    b.sym_i = '0; b.sym_valid_i = 0; b.sync_clr_i = 0; b.dout_ready_i = 1;
    bs.sym_i = '0; bs.sym_valid_i = 0; bs.sync_clr_i = 0; bs.dout_ready_i = 1;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(b.dout_o), 32'd0);
    check("rst_valid", 32'(b.dout_valid_o), 32'd0);
    check("rst_lowconf", 32'(b.lowconf_cnt_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(b.sym_ready_o), 32'd1);

    // Basic word, ready held high.
    for (int i = 0; i < 8; i++) send(tv1[i], "basic");
`ifdef BPSK_DIFF_DECODE_EN
    check("basic_word_const", 32'(b.dout_o), 32'h00EF);
`else
    check("basic_word_const", 32'(b.dout_o), 32'h00B5);
`endif
    check("basic_lowconf_const", 32'(b.lowconf_cnt_o), 32'd5);
    @(negedge clk);
    check("basic_valid_drop", 32'(b.dout_valid_o), 32'd0);

    // Back-pressure: first word held, completing bit of second word stalls.
    b.dout_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(rand_sample(), "stall_a");
    word_a = m_last_word;
    for (int i = 0; i < 7; i++) send(rand_sample(), "stall_b");
    s8 = rand_sample();
    b.sym_i = SW'(s8);
    b.sym_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_ready", 32'(b.sym_ready_o), 32'd0);
      check("stall_hold_dout", 32'(b.dout_o), 32'(word_a));
      check("stall_hold_valid", 32'(b.dout_valid_o), 32'd1);
    end
    b.dout_ready_i = 1'b1;
    send(s8, "stall_b_last");

    // Sync clear blocks the presented symbol and discards the partial word.
    for (int i = 0; i < 3; i++) send(rand_sample(), "pre_clr");
    b.sym_i       = SW'(1);
    b.sym_valid_i = 1'b1;
    b.sync_clr_i  = 1'b1;
    #1;
    check("clr_ready", 32'(b.sym_ready_o), 32'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    b.sync_clr_i  = 1'b0;
    b.sym_valid_i = 1'b0;
    check("clr_lowconf", 32'(b.lowconf_cnt_o), 32'd0);
    for (int i = 0; i < 8; i++) send(tv2[i], "post_clr");
`ifdef BPSK_DIFF_DECODE_EN
    check("diff_word_const", 32'(b.dout_o), 32'h00AC);
`else
    check("raw_word_const", 32'(b.dout_o), 32'h00C8);
`endif
    check("post_clr_lowconf_const", 32'(b.lowconf_cnt_o), 32'd3);

    // Saturation on the narrow-counter instance.
    bs.sym_i       = '0;
    bs.sym_valid_i = 1'b1;
    repeat (10) @(negedge clk);
    check("sat_mid", 32'(bs.lowconf_cnt_o), 32'd10);
    repeat (10) @(negedge clk);
    check("sat_top", 32'(bs.lowconf_cnt_o), 32'd15);
    bs.sym_valid_i = 1'b0;

    // Reset mid-word with a held output word.
    b.dout_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send(rand_sample(), "prerst_a");
    for (int i = 0; i < 5; i++) send(rand_sample(), "prerst_b");
    rst = 1'b1;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    check("midrst_dout", 32'(b.dout_o), 32'd0);
    check("midrst_valid", 32'(b.dout_valid_o), 32'd0);
    check("midrst_lowconf", 32'(b.lowconf_cnt_o), 32'd0);
    check("midrst_s_lowconf", 32'(bs.lowconf_cnt_o), 32'd0);
    rst = 1'b0;
    b.dout_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) send(rand_sample(), "postrst");

    // Randomized traffic with random sink back-pressure.
    for (int i = 0; i < 64; i++) begin
      b.dout_ready_i = ($urandom_range(0, 3) != 0);
      send(rand_sample(), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
